// File: rtl/run_ctrl_reg.sv
// Run/pause holding register: captures upstream next-count values on qualifying
// ticks, with button-edge run/pause toggle, single-step, synchronous load and update strobe.
module run_ctrl_reg #(
  parameter int               WIDTH        = 6,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0,
  parameter bit               START_PAUSED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic             step,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] counter_logic,
  output logic [WIDTH-1:0] next,
  output logic             running,
  output logic             updated
);

  typedef enum logic {
    PAUSED = 1'b0,
    RUN    = 1'b1
  } state_t;

  localparam state_t RESET_STATE = START_PAUSED ? PAUSED : RUN;

  state_t state, state_d;
  logic   pause_q, step_q;
  logic   armed, armed_d;
  logic   pause_edge, step_edge, upd;

  always_comb begin
    pause_edge = pause & ~pause_q;
    step_edge  = step & ~step_q;
    // Qualification looks only at the pre-edge state and arm flag.
    upd        = tick & ((state == RUN) | armed) & ~load;

    state_d = state;
    if (pause_edge)
      state_d = (state == RUN) ? PAUSED : RUN;

    armed_d = armed;
    if (state == PAUSED) begin
      if (upd)
        armed_d = 1'b0;
      if (step_edge && !pause_edge)
        armed_d = 1'b1;
      if (pause_edge)
        armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Capture live levels so a button held through reset yields no edge.
      pause_q <= pause;
      step_q  <= step;
      state   <= RESET_STATE;
      armed   <= 1'b0;
      updated <= 1'b0;
      next    <= RESET_VAL;
    end else begin
      pause_q <= pause;
      step_q  <= step;
      state   <= state_d;
      armed   <= armed_d;
      updated <= upd;
      if (load)
        next <= load_val;
      else if (upd)
        next <= counter_logic;
    end
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_run_ctrl_reg.sv
// Directed self-checking bench for run_ctrl_reg: default instance plus an
// 8-bit, start-paused instance for reset-value and held-button behaviour.
module tb_run_ctrl_reg;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance (WIDTH=6, RESET_VAL=0, START_PAUSED=0)
  logic       a_rst, a_pause, a_step, a_tick, a_load;
  logic [5:0] a_load_val, a_cl, a_next;
  logic       a_running, a_updated;

  // WIDTH=8, RESET_VAL=99, START_PAUSED=1
  logic       b_rst, b_pause, b_step, b_tick, b_load;
  logic [7:0] b_load_val, b_cl, b_next;
  logic       b_running, b_updated;

  int n_cmp = 0;
  int n_bad = 0;

  run_ctrl_reg dut_a (
    .clk(clk), .rst(a_rst), .pause(a_pause), .step(a_step), .tick(a_tick),
    .load(a_load), .load_val(a_load_val), .counter_logic(a_cl),
    .next(a_next), .running(a_running), .updated(a_updated)
  );

  run_ctrl_reg #(.WIDTH(8), .RESET_VAL(8'd99), .START_PAUSED(1'b1)) dut_b (
    .clk(clk), .rst(b_rst), .pause(b_pause), .step(b_step), .tick(b_tick),
    .load(b_load), .load_val(b_load_val), .counter_logic(b_cl),
    .next(b_next), .running(b_running), .updated(b_updated)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    a_rst = 1'b1; a_pause = 1'b0; a_step = 1'b0; a_tick = 1'b0;
    a_load = 1'b0; a_load_val = 6'd0; a_cl = 6'd5;
    b_rst = 1'b1; b_pause = 1'b1; b_step = 1'b0; b_tick = 1'b1;
    b_load = 1'b0; b_load_val = 8'd0; b_cl = 8'd50;
    cyc(); cyc();

    // Reset state and first update
    a_rst = 1'b0;
    chk("rst_next", a_next, 0);
    chk("rst_running", a_running, 1);
    chk("rst_updated", a_updated, 0);
    a_tick = 1'b1; cyc(); a_tick = 1'b0;
    chk("tick1_next", a_next, 5);
    chk("tick1_updated", a_updated, 1);
    cyc();
    chk("tick1_strobe_end", a_updated, 0);

    // Pause press coincident with tick acts on the old (RUN) state
    a_cl = 6'd9; a_pause = 1'b1; a_tick = 1'b1; cyc();
    chk("pause_running", a_running, 0);
    chk("pause_tick_old_state", a_next, 9);
    a_cl = 6'd11;
    for (int i = 0; i < 9; i++) begin
      a_tick = (i % 2 == 0); cyc();
    end
    a_tick = 1'b0;
    chk("paused_frozen", a_next, 9);
    chk("paused_still", a_running, 0);
    a_pause = 1'b0; cyc();
    chk("release_no_toggle", a_running, 0);
    a_pause = 1'b1; cyc();
    chk("second_press_run", a_running, 1);
    a_pause = 1'b0; a_tick = 1'b1; cyc(); a_tick = 1'b0;
    chk("resume_next", a_next, 11);
    chk("resume_updated", a_updated, 1);

    // Single step while paused
    a_pause = 1'b1; cyc(); a_pause = 1'b0; cyc();
    chk("step_paused", a_running, 0);
    a_cl = 6'd17; a_step = 1'b1; cyc();
    a_tick = 1'b1; cyc();
    chk("step_next", a_next, 17);
    chk("step_updated", a_updated, 1);
    a_cl = 6'd20; cyc();
    chk("step_once_next", a_next, 17);
    chk("step_once_updated", a_updated, 0);
    cyc(); a_tick = 1'b0;
    chk("step_held_next", a_next, 17);
    a_step = 1'b0; cyc();

    // Load beats tick in RUN
    a_pause = 1'b1; cyc(); a_pause = 1'b0; cyc();
    chk("load_pre_run", a_running, 1);
    a_load = 1'b1; a_load_val = 6'd42; a_tick = 1'b1; a_cl = 6'd3; cyc();
    a_load = 1'b0; a_tick = 1'b0;
    chk("load_next", a_next, 42);
    chk("load_updated", a_updated, 0);
    chk("load_running", a_running, 1);

    // Armed, then pause edge with tick: back to RUN and arm discarded
    a_pause = 1'b1; cyc(); a_pause = 1'b0; cyc();
    a_cl = 6'd7; a_step = 1'b1; cyc(); a_step = 1'b0;
    a_pause = 1'b1; a_tick = 1'b1; cyc();
    a_pause = 1'b0; a_tick = 1'b0;
    chk("arm_pause_running", a_running, 1);
    a_cl = 6'd8; a_tick = 1'b1; cyc(); a_tick = 1'b0;
    chk("arm_resume_next", a_next, 8);
    chk("arm_resume_updated", a_updated, 1);
    a_pause = 1'b1; cyc(); a_pause = 1'b0;
    a_cl = 6'd12; a_tick = 1'b1; cyc(); a_tick = 1'b0;
    chk("arm_cleared_next", a_next, 8);
    chk("arm_cleared_running", a_running, 0);

    // Step edge with tick while paused: arm only, update on next tick
    a_cl = 6'd13; a_step = 1'b1; a_tick = 1'b1; cyc();
    chk("step_tick_same_next", a_next, 8);
    chk("step_tick_same_updated", a_updated, 0);
    cyc(); a_tick = 1'b0;
    chk("step_tick_later_next", a_next, 13);
    chk("step_tick_later_updated", a_updated, 1);
    a_step = 1'b0;

    // Parametrised instance: pause held through reset, reset value 99
    b_rst = 1'b0; b_tick = 1'b0;
    chk("b_rst_next", b_next, 99);
    chk("b_rst_running", b_running, 0);
    cyc();
    chk("b_held_no_toggle", b_running, 0);
    cyc();
    chk("b_held_no_toggle2", b_running, 0);
    b_pause = 1'b0; cyc();
    b_pause = 1'b1; cyc();
    chk("b_press_run", b_running, 1);
    b_pause = 1'b0; b_cl = 8'd200; b_tick = 1'b1; cyc();
    chk("b_wide_next", b_next, 200);
    chk("b_wide_updated", b_updated, 1);
    b_rst = 1'b1; cyc();
    chk("b_midrst_next", b_next, 99);
    chk("b_midrst_updated", b_updated, 0);
    chk("b_midrst_running", b_running, 0);
    b_rst = 1'b0; b_tick = 1'b0; cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
